// File: rtl/round_pack_pipe_pkg.sv
// round_pack_pipe_pkg: shared types and constants for the FP32 round/pack pipeline.
// Latency: n/a (package). Backpressure: n/a.
// Contents: rounding-mode enum, exponent/fraction constants, IEEE single field struct.
package round_pack_pipe_pkg;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,  // round to nearest, ties to even
    RM_RZ  = 2'b01,  // round toward zero
    RM_RUP = 2'b10,  // round toward +inf
    RM_RDN = 2'b11   // round toward -inf
  } rnd_mode_e;

  localparam int EXP_MAX = 255;
  localparam int BIAS    = 127;
  localparam int FRAC_W  = 23;
  localparam int EXP_W   = 10;

  typedef struct packed {
    logic              sign;
    logic [7:0]        exp;
    logic [FRAC_W-1:0] frac;
  } ieee_single_t;

  // Magnitudes (sign excluded) used when an overflow is resolved.
  localparam logic [30:0] MAG_INF        = 31'h7F80_0000;
  localparam logic [30:0] MAG_MAX_FINITE = 31'h7F7F_FFFF;

endpackage

// File: rtl/round_pack_pipe_inc.sv
// round_inc: decides whether the truncated mantissa is incremented by one ulp.
// Latency: combinational. Backpressure: none (pure function of its inputs).
// Ports: rnd_mode/sign/lsb/guard/sticky in, inc out.
// Build option: ROUND_MODES_EN enables RZ/RUP/RDN; otherwise rnd_mode and sign are
// ignored and round-to-nearest-even is always applied.
module round_inc
  import round_pack_pipe_pkg::*;
(
  input  logic [1:0] rnd_mode,
  input  logic       sign,
  input  logic       lsb,
  input  logic       guard,
  input  logic       sticky,
  output logic       inc
);

`ifdef ROUND_MODES_EN
  always_comb begin
    inc = 1'b0;
    case (rnd_mode_e'(rnd_mode))
      RM_RNE:  inc = guard & (sticky | lsb);
      RM_RZ:   inc = 1'b0;
      RM_RUP:  inc = !sign & (guard | sticky);
      RM_RDN:  inc = sign & (guard | sticky);
      default: inc = 1'b0;
    endcase
  end
`else
  // Mode and sign do not influence nearest-even rounding.
  logic w_unused_mode;
  assign w_unused_mode = ^{rnd_mode, sign};
  assign inc = guard & (sticky | lsb);
`endif

endmodule

// File: rtl/round_pack_pipe.sv
// round_pack_pipe: rounds a normalized FP32 product and packs it with exception flags.
// Latency: 2 cycles (S1 round, S2 exponent adjust/exceptions/pack); 1 result/cycle.
// Backpressure: valid/ready; both stages hold while out_ready is low, in_ready = !s1_vld | s1_adv.
// Ports: clk, rst (sync, active-high); in_valid/in_ready + sign, norm_exponent[9:0],
//   norm_mantissa[22:0], guard, sticky, rnd_mode[1:0]; out_valid/out_ready + result[31:0],
//   overflow, underflow, inexact.
// Build option: ROUND_MODES_EN honours RZ/RUP/RDN (including max-finite overflow results).
module round_pack_pipe
  import round_pack_pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign,
  input  logic [EXP_W-1:0]  norm_exponent,
  input  logic [FRAC_W-1:0] norm_mantissa,
  input  logic              guard,
  input  logic              sticky,
  input  logic [1:0]        rnd_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       result,
  output logic              overflow,
  output logic              underflow,
  output logic              inexact
);

  // ---------------- handshake ----------------
  logic w_s1_adv;
  logic w_inc;
  logic [FRAC_W+1:0] w_sum;

  logic              r_s1_vld;
  logic              r_s1_sign;
  logic              r_s1_inx;
  logic [EXP_W-1:0]  r_s1_exp;
  logic [FRAC_W+1:0] r_s1_sum;
`ifdef ROUND_MODES_EN
  logic [1:0]        r_s1_mode;
`endif

  logic              r_s2_vld;
  ieee_single_t      r_s2_res;
  logic              r_s2_ovf;
  logic              r_s2_unf;
  logic              r_s2_inx;

  assign w_s1_adv = !r_s2_vld | out_ready;
  assign in_ready = !r_s1_vld | w_s1_adv;

  // ---------------- S1: round ----------------
  round_inc u_round_inc (
    .rnd_mode (rnd_mode),
    .sign     (sign),
    .lsb      (norm_mantissa[0]),
    .guard    (guard),
    .sticky   (sticky),
    .inc      (w_inc)
  );

  // {carry, hidden 1, fraction} + inc; bit 24 set means the mantissa rolled over to 2.0.
  assign w_sum = {2'b01, norm_mantissa} + {{(FRAC_W+1){1'b0}}, w_inc};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_sign <= 1'b0;
      r_s1_inx  <= 1'b0;
      r_s1_exp  <= '0;
      r_s1_sum  <= '0;
`ifdef ROUND_MODES_EN
      r_s1_mode <= 2'b00;
`endif
    end else if (in_ready) begin
      r_s1_vld <= in_valid;
      if (in_valid) begin
        r_s1_sign <= sign;
        r_s1_inx  <= guard | sticky;
        r_s1_exp  <= norm_exponent;
        r_s1_sum  <= w_sum;
`ifdef ROUND_MODES_EN
        r_s1_mode <= rnd_mode;
`endif
      end
    end
  end

  // ---------------- S2: exponent adjust, exceptions, pack ----------------
  logic [EXP_W-1:0] w_exp_adj;
  logic             w_ovf;
  logic             w_unf;
  logic             w_ovf_to_max;
  ieee_single_t     w_pack;
  logic             w_inx;

  // 10-bit wrap is intentional: an exponent of 511 plus carry becomes negative.
  assign w_exp_adj = r_s1_sum[FRAC_W+1] ? r_s1_exp + 10'd1 : r_s1_exp;
  assign w_ovf     = !w_exp_adj[EXP_W-1] && (w_exp_adj >= EXP_W'(EXP_MAX));
  assign w_unf     = w_exp_adj[EXP_W-1] || (w_exp_adj == '0);

`ifdef ROUND_MODES_EN
  // Directed modes that round away from infinity saturate to the largest finite value.
  always_comb begin
    w_ovf_to_max = 1'b0;
    case (rnd_mode_e'(r_s1_mode))
      RM_RZ:   w_ovf_to_max = 1'b1;
      RM_RUP:  w_ovf_to_max = r_s1_sign;
      RM_RDN:  w_ovf_to_max = !r_s1_sign;
      default: w_ovf_to_max = 1'b0;
    endcase
  end
`else
  assign w_ovf_to_max = 1'b0;
`endif

  always_comb begin
    w_pack.sign = r_s1_sign;
    w_pack.exp  = w_exp_adj[7:0];
    w_pack.frac = r_s1_sum[FRAC_W+1] ? '0 : r_s1_sum[FRAC_W-1:0];
    w_inx       = r_s1_inx;
    if (w_ovf) begin
      {w_pack.exp, w_pack.frac} = w_ovf_to_max ? MAG_MAX_FINITE : MAG_INF;
      w_inx = 1'b1;
    end else if (w_unf) begin
      // Flush to signed zero; denormals are not produced.
      w_pack.exp  = '0;
      w_pack.frac = '0;
      w_inx       = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_vld <= 1'b0;
      r_s2_res <= '0;
      r_s2_ovf <= 1'b0;
      r_s2_unf <= 1'b0;
      r_s2_inx <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_res <= w_pack;
        r_s2_ovf <= w_ovf;
        r_s2_unf <= w_unf & !w_ovf;
        r_s2_inx <= w_inx;
      end
    end
  end

  assign out_valid = r_s2_vld;
  assign result    = r_s2_res;
  assign overflow  = r_s2_ovf;
  assign underflow = r_s2_unf;
  assign inexact   = r_s2_inx;

endmodule

// File: tb/tb_round_pack_pipe.sv
// tb_round_pack_pipe: directed vectors with a scoreboard queue and an independent monitor.
module tb_round_pack_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        sign;
  logic [9:0]  norm_exponent;
  logic [22:0] norm_mantissa;
  logic        guard;
  logic        sticky;
  logic [1:0]  rnd_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        inexact;

  round_pack_pipe dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .sign          (sign),
    .norm_exponent (norm_exponent),
    .norm_mantissa (norm_mantissa),
    .guard         (guard),
    .sticky        (sticky),
    .rnd_mode      (rnd_mode),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .overflow      (overflow),
    .underflow     (underflow),
    .inexact       (inexact)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flags;   // {overflow, underflow, inexact}
    int          lat_cyc; // expected cycle of first appearance, -1 = unchecked
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pushed = 0;
  int   popped = 0;
  bit   c_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: compares the head of the scoreboard every cycle a result is presented
  // (so stalled outputs must stay equal to it) and pops on transfer.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        if (out_ready) begin
          checks++;
          errors++;
          popped++;
          $display("FAIL unexpected_output: got %h expected none", result);
        end
      end else begin
        e = sb[0];
        check("result", result, e.res);
        check("flags", {29'd0, overflow, underflow, inexact}, {29'd0, e.flags});
        if (out_ready) begin
          if (e.lat_cyc >= 0) check("latency_cycle", cyc, e.lat_cyc);
          void'(sb.pop_front());
          popped++;
        end
      end
    end
  end

  task automatic send(input logic s, input logic [9:0] e, input logic [22:0] m,
                      input logic g, input logic st, input logic [1:0] rm,
                      input logic [31:0] xres, input logic [2:0] xflags, input bit lat);
    int   n = 0;
    exp_t x;
    sign = s; norm_exponent = e; norm_mantissa = m;
    guard = g; sticky = st; rnd_mode = rm; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
    end else begin
      x.res = xres;
      x.flags = xflags;
      x.lat_cyc = lat ? cyc + 2 : -1;
      sb.push_back(x);
      pushed++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("drain_queue_empty", sb.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int t0;
    in_valid = 0; sign = 0; norm_exponent = 0; norm_mantissa = 0;
    guard = 0; sticky = 0; rnd_mode = 0; out_ready = 1; rst = 1; c_done = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_result", result, 0);
    check("rst_flags", {29'd0, overflow, underflow, inexact}, 0);
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 1);
    @(posedge clk); #1;

    // Tie to even with latency check.
    send(0, 10'd127, 23'h0, 1, 0, 2'b00, 32'h3F80_0000, 3'b001, 1);
    wait_drain();
    @(posedge clk); #1;

    // Back-to-back directed vectors (also exercises 1 result/cycle throughput).
    t0 = cyc;
    send(0, 10'd127, 23'h7FFFFF, 1, 1, 2'b00, 32'h4000_0000, 3'b001, 0); // carry
    send(0, 10'd254, 23'h7FFFFF, 1, 0, 2'b00, 32'h7F80_0000, 3'b101, 0); // overflow
    send(1, 10'h3F6, 23'h0,      0, 0, 2'b00, 32'h8000_0000, 3'b011, 0); // underflow
    send(0, 10'd100, 23'h123456, 0, 0, 2'b00, 32'h3212_3456, 3'b000, 0); // exact
    check("throughput_cycles", cyc - t0, 4);
    send(1, 10'd127, 23'h000001, 1, 0, 2'b00, 32'hBF80_0002, 3'b001, 0); // tie, odd lsb
    send(0, 10'd0,   23'h0,      0, 0, 2'b00, 32'h0000_0000, 3'b011, 0); // exp 0
    send(1, 10'd255, 23'h0,      0, 0, 2'b00, 32'hFF80_0000, 3'b101, 0); // exp 255
    send(0, 10'd0,   23'h7FFFFF, 1, 1, 2'b00, 32'h0080_0000, 3'b001, 0); // carry out of 0
    send(0, 10'h3FF, 23'h7FFFFF, 1, 1, 2'b00, 32'h0000_0000, 3'b011, 0); // -1 carry to 0
    send(0, 10'd254, 23'h7FFFFF, 0, 0, 2'b00, 32'h7F7F_FFFF, 3'b000, 0); // max finite exact
    send(0, 10'd130, 23'h0,      0, 1, 2'b00, 32'h4100_0000, 3'b001, 0); // sticky only
`ifdef ROUND_MODES_EN
    send(0, 10'd254, 23'h7FFFFF, 1, 0, 2'b01, 32'h7F7F_FFFF, 3'b001, 0); // RZ, no carry
    send(0, 10'd255, 23'h0,      0, 0, 2'b01, 32'h7F7F_FFFF, 3'b101, 0); // RZ overflow
    send(1, 10'd255, 23'h0,      0, 0, 2'b10, 32'hFF7F_FFFF, 3'b101, 0); // RUP neg
    send(0, 10'd255, 23'h0,      0, 0, 2'b10, 32'h7F80_0000, 3'b101, 0); // RUP pos
    send(1, 10'd255, 23'h0,      0, 0, 2'b11, 32'hFF80_0000, 3'b101, 0); // RDN neg
    send(0, 10'd255, 23'h0,      0, 0, 2'b11, 32'h7F7F_FFFF, 3'b101, 0); // RDN pos
    send(0, 10'd127, 23'h0,      0, 1, 2'b10, 32'h3F80_0001, 3'b001, 0); // RUP rounds up
    send(1, 10'd127, 23'h7FFFFF, 1, 1, 2'b01, 32'hBFFF_FFFF, 3'b001, 0); // RZ truncates
`else
    send(0, 10'd127, 23'h7FFFFF, 1, 1, 2'b01, 32'h4000_0000, 3'b001, 0); // mode ignored
    send(0, 10'd255, 23'h0,      0, 0, 2'b11, 32'h7F80_0000, 3'b101, 0); // mode ignored
`endif
    wait_drain();

    // Stall: three inputs while out_ready is low for 5 cycles.
    @(posedge clk); #1;
    out_ready = 0;
    send(0, 10'd127, 23'h7FFFFF, 1, 1, 2'b00, 32'h4000_0000, 3'b001, 0);
    send(0, 10'd100, 23'h123456, 0, 0, 2'b00, 32'h3212_3456, 3'b000, 0);
    fork
      begin
        send(1, 10'd127, 23'h000001, 1, 0, 2'b00, 32'hBF80_0002, 3'b001, 0);
        c_done = 1;
      end
    join_none
    @(negedge clk);
    check("stall_in_ready", {31'd0, in_ready}, 0);
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1;
    for (int n = 0; n < 50 && !c_done; n++) @(negedge clk);
    check("stall_third_accepted", {31'd0, c_done}, 1);
    wait_drain();
    check("stall_all_delivered", popped, pushed);

    // Reset with two results in flight.
    @(posedge clk); #1;
    out_ready = 0;
    send(0, 10'd127, 23'h0, 1, 0, 2'b00, 32'h3F80_0000, 3'b001, 0);
    send(0, 10'd130, 23'h0, 0, 1, 2'b00, 32'h4100_0000, 3'b001, 0);
    rst = 1;
    @(posedge clk); #1;
    check("rst_flush_out_valid", {31'd0, out_valid}, 0);
    check("rst_flush_result", result, 0);
    sb.delete();
    pushed -= 2;
    rst = 0;
    out_ready = 1;
    repeat (10) @(posedge clk);
    #1;
    send(1, 10'd100, 23'h123456, 0, 0, 2'b00, 32'hB212_3456, 3'b000, 1);
    wait_drain();
    check("total_delivered", popped, pushed);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/round_pack_pipe.md
ROUND_PACK_PIPE -- requirements
Module: round_pack_pipe

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 The block SHALL expose these ports (name  direction  width  meaning):
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  upstream normalizer result valid
- in_ready  out  1  block can accept input this cycle
- sign  in  1  product sign (sign_a XOR sign_b)
- norm_exponent  in  10  signed two's-complement biased exponent from the normalizer
- norm_mantissa  in  23  normalized fraction; hidden 1 implied
- guard  in  1  first discarded bit
- sticky  in  1  OR of all remaining discarded bits
- rnd_mode  in  2  00 RNE, 01 RZ, 10 RUP (+inf), 11 RDN (-inf)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  32  packed IEEE-754 single {sign, exp[7:0], frac[22:0]}
- overflow  out  1  result overflowed
- underflow  out  1  result flushed to zero
- inexact  out  1  guard|sticky set, or overflow/underflow occurred

Function
REQ-003 The block SHALL be a 2-stage pipeline: S1 rounds, S2 adjusts the exponent, detects exceptions and packs; latency is 2 cycles with no stall.
REQ-004 Handshake: transfer on valid&ready; in_ready = !s1_valid | s1_advance; s1_advance = !s2_valid | out_ready; stages hold contents while stalled.
REQ-005 out_valid, result and flags SHALL stay stable while out_valid=1 and out_ready=0.
REQ-006 S1 SHALL compute a 25-bit sum {1'b0,1'b1,norm_mantissa} + inc; RNE: inc = guard&(sticky|norm_mantissa[0]).
REQ-007 On a carry into sum[24], S2 SHALL use fraction 0 and exponent norm_exponent+1, evaluated in 10-bit signed arithmetic.
REQ-008 Overflow: if the adjusted exponent is >= 255 (signed), then RNE gives ±inf (exp 0xFF, frac 0), overflow=1, inexact=1.
REQ-009 Underflow: if the adjusted exponent is <= 0 (signed), result = {sign,31'b0} (flush, no denormals), underflow=1, inexact=1.
REQ-010 Otherwise result = {sign, exp[7:0], sum[22:0]}, overflow=0, underflow=0, inexact = guard|sticky.
REQ-011 Simultaneous input accept and output drain in one cycle SHALL sustain a throughput of 1 result/cycle.

Reset
REQ-012 While rst=1, s1_valid, s2_valid and out_valid SHALL be 0; result and flags 0; in_ready=1 from the cycle after reset.
REQ-013 Reset mid-operation SHALL discard all in-flight results with no output emitted.

Configuration
REQ-014 Macro ROUND_MODES_EN: when defined, all four rnd_mode values SHALL be honoured.
- RZ: inc=0.
- RUP: inc = !sign&(guard|sticky).
- RDN: inc = sign&(guard|sticky).
REQ-015 With ROUND_MODES_EN defined, on overflow:
- RZ returns ±0x7F7FFFFF magnitude (max finite).
- RUP returns +inf for positive, max finite for negative.
- RDN returns -inf for negative, max finite for positive.
REQ-016 Without ROUND_MODES_EN, the rnd_mode port SHALL remain but be ignored; RNE is always used.

Structure
REQ-017 A shared package SHALL hold:
- the rounding-mode enum;
- the constants EXP_MAX=255, BIAS=127, FRAC_W=23, EXP_W=10;
- a packed struct for the IEEE single fields.
REQ-018 One sub-module, round_inc, SHALL compute inc from {rnd_mode, sign, lsb, guard, sticky}; the rest is inline.

Verification
REQ-019 Bench scenarios:
- norm_exponent=127, norm_mantissa=0, guard=1, sticky=0, sign=0, RNE -> result 0x3F800000 (tie to even), inexact=1, out_valid 2 cycles after accept.
- norm_exponent=127, norm_mantissa=0x7FFFFF, guard=1, sticky=1, RNE -> carry; result 0x40000000, inexact=1.
- norm_exponent=254, norm_mantissa=0x7FFFFF, guard=1, sticky=0, RNE -> 0x7F800000, overflow=1, inexact=1; with ROUND_MODES_EN and RZ -> 0x7F7FFFFF.
- norm_exponent=10'h3F6 (-10), sign=1 -> result 0x80000000, underflow=1, inexact=1.
- out_ready held 0 for 5 cycles over 3 back-to-back inputs -> in_ready drops after 2 accepted; result stable; all 3 delivered in order once out_ready=1.
- rst asserted with 2 results in flight -> out_valid=0 next cycle; no stale result emitted afterwards.
